ls_issue_queue: RTL and testbench

- In-order load/store queue that sits between rename/dispatch and the data-memory stage.
- Holds dispatched memory ops and captures base/data operands from the writeback wakeup buses.
- Computes the effective address and issues at most one op per cycle to data memory (valid_ls/mode/busX/Addr/tag_ROB_ls/Px).
- Stores are back-pressured by the memory store buffer's full_FIFO; the whole back end is held by freeze_back and cleared by flush.

---
 rtl/lsq_pkg.sv | 38 +++
 rtl/lsq_wakeup_match.sv | 31 +++
 rtl/ls_issue_queue.sv | 190 +++++++++++++++++++
 tb/tb_ls_issue_queue.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsq_pkg.sv
// Shared types and constants for the load/store issue queue.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package lsq_pkg;

  // Default geometry; the queue top uses these as its parameter defaults.
  localparam int LSQ_DEPTH  = 8;
  localparam int LSQ_DATA_W = 16;
  localparam int LSQ_ADDR_W = 16;
  localparam int LSQ_PREG_W = 5;
  localparam int LSQ_TAG_W  = 5;
  localparam int LSQ_NWB    = 3;

  // Op encoding shared with the data-memory block.
  localparam logic MODE_LOAD  = 1'b1;
  localparam logic MODE_STORE = 1'b0;

  // One queued memory op. rdy_x is always 1 for loads (Px is a destination).
  typedef struct packed {
    logic                  valid;
    logic                  mode;
    logic [LSQ_PREG_W-1:0] pa;
    logic                  rdy_a;
    logic [LSQ_DATA_W-1:0] val_a;
    logic [LSQ_PREG_W-1:0] px;
    logic                  rdy_x;
    logic [LSQ_DATA_W-1:0] val_x;
    logic [LSQ_ADDR_W-1:0] imm;
    logic [LSQ_TAG_W-1:0]  tag;
  } lsq_entry_t;

  // Effective address: base + offset, wrapping modulo 2^ADDR_W.
  function automatic logic [LSQ_ADDR_W-1:0] eff_addr(input logic [LSQ_DATA_W-1:0] base,
                                                      input logic [LSQ_ADDR_W-1:0] off);
    return LSQ_ADDR_W'(base) + off;
  endfunction

endpackage

// File: rtl/lsq_wakeup_match.sv
// Matches one physical register against all writeback ports, returns hit + value.
// Latency: purely combinational.
// Backpressure: none; lowest-numbered matching port wins when several hit.
module lsq_wakeup_match
  import lsq_pkg::*;
#(
  parameter int NWB    = LSQ_NWB,
  parameter int PREG_W = LSQ_PREG_W,
  parameter int DATA_W = LSQ_DATA_W
) (
  input  logic [PREG_W-1:0]     preg,
  input  logic [NWB-1:0]        wake_valid,
  input  logic [NWB*PREG_W-1:0] wake_P,
  input  logic [NWB*DATA_W-1:0] wake_data,
  output logic                  hit,
  output logic [DATA_W-1:0]     data
);

  // Scan from the highest port down so the lowest matching port overwrites last.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = NWB - 1; k >= 0; k--) begin
      if (wake_valid[k] && (wake_P[k*PREG_W +: PREG_W] == preg)) begin
        hit  = 1'b1;
        data = wake_data[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/ls_issue_queue.sv
// In-order load/store queue: captures operands from wakeup, issues head op to data memory.
// Latency: issue outputs are registered, valid_ls rises the cycle after the head becomes issuable.
// Backpressure: full_lsq stalls dispatch; full_FIFO blocks stores at head (and all younger ops); freeze_back holds outputs.
module ls_issue_queue
  import lsq_pkg::*;
#(
  // The entry struct is sized by the package constants; keep these equal to them.
  parameter int DEPTH  = LSQ_DEPTH,
  parameter int DATA_W = LSQ_DATA_W,
  parameter int ADDR_W = LSQ_ADDR_W,
  parameter int PREG_W = LSQ_PREG_W,
  parameter int TAG_W  = LSQ_TAG_W,
  parameter int NWB    = LSQ_NWB
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  freeze_back,
  input  logic                  valid_dis,
  input  logic                  mode_dis,
  input  logic [PREG_W-1:0]     Pa_dis,
  input  logic                  rdy_a_dis,
  input  logic [DATA_W-1:0]     busA_dis,
  input  logic [PREG_W-1:0]     Px_dis,
  input  logic                  rdy_x_dis,
  input  logic [DATA_W-1:0]     busX_dis,
  input  logic [ADDR_W-1:0]     imm_dis,
  input  logic [TAG_W-1:0]      tag_ROB_dis,
  output logic                  full_lsq,
  input  logic [NWB-1:0]        wake_valid,
  input  logic [NWB*PREG_W-1:0] wake_P,
  input  logic [NWB*DATA_W-1:0] wake_data,
  input  logic                  full_FIFO,
  output logic                  valid_ls,
  output logic                  mode,
  output logic [DATA_W-1:0]     busX,
  output logic [ADDR_W-1:0]     Addr,
  output logic [TAG_W-1:0]      tag_ROB_ls,
  output logic [PREG_W-1:0]     Px
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  lsq_entry_t        q [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic [DEPTH-1:0]  hit_a;
  logic [DEPTH-1:0]  hit_x;
  logic [DATA_W-1:0] wdat_a [DEPTH];
  logic [DATA_W-1:0] wdat_x [DEPTH];

  logic              dhit_a;
  logic              dhit_x;
  logic [DATA_W-1:0] ddat_a;
  logic [DATA_W-1:0] ddat_x;

  lsq_entry_t        dis_ent;
  logic              dis_ok;
  logic              iss_ok;

  assign full_lsq = (count == FULL_CNT);

  // Dispatch is refused while full even if the head issues this same cycle.
  assign dis_ok = valid_dis && !full_lsq && !flush;

  // Only the head may issue; a store stuck on full_FIFO holds back everything behind it.
  assign iss_ok = q[head].valid && q[head].rdy_a && q[head].rdy_x &&
                  !freeze_back && !flush &&
                  ((q[head].mode == MODE_LOAD) || !full_FIFO);

  // Per-entry wakeup comparators for the base and store-data operands.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    lsq_wakeup_match #(.NWB(NWB), .PREG_W(PREG_W), .DATA_W(DATA_W)) u_match_a (
      .preg       (q[i].pa),
      .wake_valid (wake_valid),
      .wake_P     (wake_P),
      .wake_data  (wake_data),
      .hit        (hit_a[i]),
      .data       (wdat_a[i])
    );
    lsq_wakeup_match #(.NWB(NWB), .PREG_W(PREG_W), .DATA_W(DATA_W)) u_match_x (
      .preg       (q[i].px),
      .wake_valid (wake_valid),
      .wake_P     (wake_P),
      .wake_data  (wake_data),
      .hit        (hit_x[i]),
      .data       (wdat_x[i])
    );
  end

  // Bypass comparators so an op dispatched alongside its producer's writeback is not lost.
  lsq_wakeup_match #(.NWB(NWB), .PREG_W(PREG_W), .DATA_W(DATA_W)) u_dis_match_a (
    .preg       (Pa_dis),
    .wake_valid (wake_valid),
    .wake_P     (wake_P),
    .wake_data  (wake_data),
    .hit        (dhit_a),
    .data       (ddat_a)
  );
  lsq_wakeup_match #(.NWB(NWB), .PREG_W(PREG_W), .DATA_W(DATA_W)) u_dis_match_x (
    .preg       (Px_dis),
    .wake_valid (wake_valid),
    .wake_P     (wake_P),
    .wake_data  (wake_data),
    .hit        (dhit_x),
    .data       (ddat_x)
  );

  // Build the entry written at tail, folding in same-cycle wakeups.
  always_comb begin
    dis_ent       = '0;
    dis_ent.valid = 1'b1;
    dis_ent.mode  = mode_dis;
    dis_ent.pa    = Pa_dis;
    dis_ent.rdy_a = rdy_a_dis || dhit_a;
    dis_ent.val_a = rdy_a_dis ? busA_dis : ddat_a;
    dis_ent.px    = Px_dis;
    dis_ent.imm   = imm_dis;
    dis_ent.tag   = tag_ROB_dis;
    if (mode_dis == MODE_LOAD) begin
      dis_ent.rdy_x = 1'b1;
    end else begin
      dis_ent.rdy_x = rdy_x_dis || dhit_x;
      dis_ent.val_x = rdy_x_dis ? busX_dis : ddat_x;
    end
  end

  // Queue storage, operand capture, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q[i].valid && !q[i].rdy_a && hit_a[i]) begin
          q[i].rdy_a <= 1'b1;
          q[i].val_a <= wdat_a[i];
        end
        if (q[i].valid && !q[i].rdy_x && hit_x[i]) begin
          q[i].rdy_x <= 1'b1;
          q[i].val_x <= wdat_x[i];
        end
      end
      if (iss_ok) begin
        q[head].valid <= 1'b0;
        head          <= head + PTR_W'(1);
      end
      // Head and tail only alias when empty (no issue) or full (no dispatch).
      if (dis_ok) begin
        q[tail] <= dis_ent;
        tail    <= tail + PTR_W'(1);
      end
      case ({dis_ok, iss_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered issue port: load on issue, hold under freeze, otherwise just drop valid.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_ls   <= 1'b0;
      mode       <= 1'b0;
      busX       <= '0;
      Addr       <= '0;
      tag_ROB_ls <= '0;
      Px         <= '0;
    end else if (iss_ok) begin
      valid_ls   <= 1'b1;
      mode       <= q[head].mode;
      busX       <= (q[head].mode == MODE_STORE) ? q[head].val_x : '0;
      Addr       <= eff_addr(q[head].val_a, q[head].imm);
      tag_ROB_ls <= q[head].tag;
      Px         <= q[head].px;
    end else if (!freeze_back) begin
      valid_ls   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ls_issue_queue.sv
// Directed bench for ls_issue_queue: vector table plus multi-cycle sequences.
// Latency: each step drives inputs, takes one clk edge, then samples outputs 1 time unit later.
// Backpressure: full_FIFO, freeze_back and full_lsq are exercised directly.
module tb_ls_issue_queue;

  logic        clk = 1'b0;
  logic        rst, flush, freeze_back;
  logic        valid_dis, mode_dis, rdy_a_dis, rdy_x_dis;
  logic [4:0]  Pa_dis, Px_dis, tag_ROB_dis;
  logic [15:0] busA_dis, busX_dis, imm_dis;
  logic        full_lsq;
  logic [2:0]  wake_valid;
  logic [14:0] wake_P;
  logic [47:0] wake_data;
  logic        full_FIFO;
  logic        valid_ls, mode;
  logic [15:0] busX, Addr;
  logic [4:0]  tag_ROB_ls, Px;

  always #5 clk = ~clk;

  ls_issue_queue #(
    .DEPTH(8), .DATA_W(16), .ADDR_W(16), .PREG_W(5), .TAG_W(5), .NWB(3)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze_back(freeze_back),
    .valid_dis(valid_dis), .mode_dis(mode_dis), .Pa_dis(Pa_dis), .rdy_a_dis(rdy_a_dis),
    .busA_dis(busA_dis), .Px_dis(Px_dis), .rdy_x_dis(rdy_x_dis), .busX_dis(busX_dis),
    .imm_dis(imm_dis), .tag_ROB_dis(tag_ROB_dis), .full_lsq(full_lsq),
    .wake_valid(wake_valid), .wake_P(wake_P), .wake_data(wake_data),
    .full_FIFO(full_FIFO), .valid_ls(valid_ls), .mode(mode), .busX(busX),
    .Addr(Addr), .tag_ROB_ls(tag_ROB_ls), .Px(Px)
  );

  typedef struct packed {
    logic        rst, flush, freeze, vdis, mdis;
    logic [4:0]  pa;
    logic        ra;
    logic [15:0] ba;
    logic [4:0]  px;
    logic        rx;
    logic [15:0] bx, imm;
    logic [4:0]  tag;
    logic [2:0]  wv;
    logic [14:0] wp;
    logic [47:0] wd;
    logic        ffull;
  } stim_t;

  typedef struct packed {
    logic        vld, mode;
    logic [15:0] bx, addr;
    logic [4:0]  tag, px;
    logic        full;
  } resp_t;

  typedef struct {
    string name;
    stim_t s;
    resp_t r;
  } vec_t;

  vec_t  tbl[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  stim_t I;
  stim_t s;

  function automatic stim_t dis(logic m, logic [4:0] pa, logic ra, logic [15:0] ba,
                                logic [4:0] px, logic rx, logic [15:0] bx,
                                logic [15:0] imm, logic [4:0] tag);
    stim_t v;
    v = '0;
    v.vdis = 1'b1; v.mdis = m; v.pa = pa; v.ra = ra; v.ba = ba;
    v.px = px; v.rx = rx; v.bx = bx; v.imm = imm; v.tag = tag;
    return v;
  endfunction

  function automatic stim_t wake(stim_t s_in, int k, logic [4:0] p, logic [15:0] d);
    stim_t v;
    v = s_in;
    v.wv[k]         = 1'b1;
    v.wp[k*5 +: 5]  = p;
    v.wd[k*16 +: 16] = d;
    return v;
  endfunction

  function automatic resp_t rsp(logic vld, logic m, logic [15:0] bx, logic [15:0] addr,
                                logic [4:0] tag, logic [4:0] px, logic full);
    resp_t r;
    r.vld = vld; r.mode = m; r.bx = bx; r.addr = addr; r.tag = tag; r.px = px; r.full = full;
    return r;
  endfunction

  task automatic add(string n, stim_t sv, resp_t rv);
    vec_t v;
    v.name = n; v.s = sv; v.r = rv;
    tbl.push_back(v);
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(stim_t sv);
    rst = sv.rst; flush = sv.flush; freeze_back = sv.freeze;
    valid_dis = sv.vdis; mode_dis = sv.mdis; Pa_dis = sv.pa; rdy_a_dis = sv.ra;
    busA_dis = sv.ba; Px_dis = sv.px; rdy_x_dis = sv.rx; busX_dis = sv.bx;
    imm_dis = sv.imm; tag_ROB_dis = sv.tag; wake_valid = sv.wv; wake_P = sv.wp;
    wake_data = sv.wd; full_FIFO = sv.ffull;
  endtask

  task automatic step(stim_t sv);
    drive(sv);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(string n, resp_t e);
    check({n, ".valid_ls"},   32'(valid_ls),   32'(e.vld));
    check({n, ".mode"},       32'(mode),       32'(e.mode));
    check({n, ".busX"},       32'(busX),       32'(e.bx));
    check({n, ".Addr"},       32'(Addr),       32'(e.addr));
    check({n, ".tag_ROB_ls"}, 32'(tag_ROB_ls), 32'(e.tag));
    check({n, ".Px"},         32'(Px),         32'(e.px));
    check({n, ".full_lsq"},   32'(full_lsq),   32'(e.full));
  endtask

  // Queue 6 ops (a ready store blocked by full_FIFO, then 5 unready loads), issue the store,
  // then clear with rst or flush while also offering a ready dispatch that must be dropped.
  task automatic clear_seq(logic use_rst, string nm);
    stim_t v;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) v = dis(1'b0, 5'd0, 1'b1, 16'h0080, 5'd0, 1'b1, 16'h5555, 16'h0000, 5'd20);
      else        v = dis(1'b1, 5'd25, 1'b0, 16'h0000, 5'(i), 1'b0, 16'h0000, 16'h0000, 5'(20 + i));
      v.ffull = 1'b1;
      step(v);
      check($sformatf("%s_fill%0d.valid_ls", nm, i), 32'(valid_ls), 32'd0);
    end
    step(I);
    cmp({nm, "_store_issue"}, rsp(1'b1, 1'b0, 16'h5555, 16'h0080, 5'd20, 5'd0, 1'b0));
    v = dis(1'b1, 5'd1, 1'b1, 16'h0099, 5'd3, 1'b0, 16'h0000, 16'h0000, 5'd30);
    if (use_rst) v.rst = 1'b1;
    else         v.flush = 1'b1;
    step(v);
    cmp({nm, "_cleared"}, rsp(1'b0, 1'b0, 16'h0000, 16'h0000, 5'd0, 5'd0, 1'b0));
    step(wake(I, 0, 5'd25, 16'h0700));
    for (int i = 0; i < 4; i++) begin
      step(I);
      check($sformatf("%s_stale%0d.valid_ls", nm, i), 32'(valid_ls), 32'd0);
      check($sformatf("%s_stale%0d.full_lsq", nm, i), 32'(full_lsq), 32'd0);
    end
  endtask

  initial begin
    I = '0;
    drive(I);

    // Basic load, store-data wakeup, dispatch bypass with port priority, entry wakeup + address wrap.
    s = I; s.rst = 1'b1;
    add("reset",      s, rsp(1'b0, 1'b0, 16'h0000, 16'h0000, 5'd0, 5'd0, 1'b0));
    add("ld_dis",     dis(1'b1, 5'd1, 1'b1, 16'h0100, 5'd7, 1'b0, 16'h0000, 16'h0004, 5'd3),
                      rsp(1'b0, 1'b0, 16'h0000, 16'h0000, 5'd0, 5'd0, 1'b0));
    add("ld_issue",   I, rsp(1'b1, 1'b1, 16'h0000, 16'h0104, 5'd3, 5'd7, 1'b0));
    add("ld_idle",    I, rsp(1'b0, 1'b1, 16'h0000, 16'h0104, 5'd3, 5'd7, 1'b0));
    add("st_dis",     dis(1'b0, 5'd2, 1'b1, 16'h0200, 5'd9, 1'b0, 16'h0000, 16'h0010, 5'd4),
                      rsp(1'b0, 1'b1, 16'h0000, 16'h0104, 5'd3, 5'd7, 1'b0));
    add("st_wait",    I, rsp(1'b0, 1'b1, 16'h0000, 16'h0104, 5'd3, 5'd7, 1'b0));
    add("st_wake",    wake(I, 2, 5'd9, 16'hBEEF),
                      rsp(1'b0, 1'b1, 16'h0000, 16'h0104, 5'd3, 5'd7, 1'b0));
    add("st_issue",   I, rsp(1'b1, 1'b0, 16'hBEEF, 16'h0210, 5'd4, 5'd9, 1'b0));
    add("st_idle",    I, rsp(1'b0, 1'b0, 16'hBEEF, 16'h0210, 5'd4, 5'd9, 1'b0));
    add("byp_dis",    wake(wake(dis(1'b0, 5'd3, 1'b0, 16'h0000, 5'd10, 1'b1, 16'h1234, 16'h0002, 5'd5),
                                1, 5'd3, 16'h0600), 0, 5'd3, 16'h0500),
                      rsp(1'b0, 1'b0, 16'hBEEF, 16'h0210, 5'd4, 5'd9, 1'b0));
    add("byp_issue",  I, rsp(1'b1, 1'b0, 16'h1234, 16'h0502, 5'd5, 5'd10, 1'b0));
    add("byp_idle",   I, rsp(1'b0, 1'b0, 16'h1234, 16'h0502, 5'd5, 5'd10, 1'b0));
    add("wrap_dis",   dis(1'b1, 5'd4, 1'b0, 16'h0000, 5'd11, 1'b0, 16'h0000, 16'hFFFF, 5'd6),
                      rsp(1'b0, 1'b0, 16'h1234, 16'h0502, 5'd5, 5'd10, 1'b0));
    add("wrap_wake",  wake(wake(I, 2, 5'd4, 16'h0020), 1, 5'd4, 16'h0010),
                      rsp(1'b0, 1'b0, 16'h1234, 16'h0502, 5'd5, 5'd10, 1'b0));
    add("wrap_issue", I, rsp(1'b1, 1'b1, 16'h0000, 16'h000F, 5'd6, 5'd11, 1'b0));
    add("wrap_idle",  I, rsp(1'b0, 1'b1, 16'h0000, 16'h000F, 5'd6, 5'd11, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].s);
      cmp(tbl[i].name, tbl[i].r);
    end

    // Store blocked by full_FIFO keeps a ready load behind it waiting.
    s = dis(1'b0, 5'd5, 1'b1, 16'h0300, 5'd12, 1'b1, 16'hAAAA, 16'h0000, 5'd7);
    s.ffull = 1'b1;
    step(s);
    check("bp_dis_st.valid_ls", 32'(valid_ls), 32'd0);
    s = dis(1'b1, 5'd6, 1'b1, 16'h0400, 5'd13, 1'b0, 16'h0000, 16'h0001, 5'd8);
    s.ffull = 1'b1;
    step(s);
    check("bp_dis_ld.valid_ls", 32'(valid_ls), 32'd0);
    for (int i = 0; i < 4; i++) begin
      s = I; s.ffull = 1'b1;
      step(s);
      check($sformatf("bp_hold%0d.valid_ls", i), 32'(valid_ls), 32'd0);
    end
    step(I);
    cmp("bp_store", rsp(1'b1, 1'b0, 16'hAAAA, 16'h0300, 5'd7, 5'd12, 1'b0));
    step(I);
    cmp("bp_load",  rsp(1'b1, 1'b1, 16'h0000, 16'h0401, 5'd8, 5'd13, 1'b0));
    step(I);
    check("bp_idle.valid_ls", 32'(valid_ls), 32'd0);

    // Fill all 8 entries (pointers start at 6, so the fill wraps), drop extra dispatches, then drain.
    for (int i = 0; i < 8; i++) begin
      step(dis(1'b1, 5'd20, 1'b0, 16'h0000, 5'(i), 1'b0, 16'h0000, 16'(2 * i), 5'(10 + i)));
      check($sformatf("fill%0d.valid_ls", i), 32'(valid_ls), 32'd0);
      check($sformatf("fill%0d.full_lsq", i), 32'(full_lsq), (i == 7) ? 32'd1 : 32'd0);
    end
    step(wake(dis(1'b1, 5'd21, 1'b1, 16'h0000, 5'd31, 1'b0, 16'h0000, 16'h0000, 5'd31),
              0, 5'd20, 16'h1000));
    check("ninth_drop.full_lsq", 32'(full_lsq), 32'd1);
    check("ninth_drop.valid_ls", 32'(valid_ls), 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (i == 0) s = dis(1'b1, 5'd22, 1'b1, 16'h0000, 5'd30, 1'b0, 16'h0000, 16'h0000, 5'd30);
      else        s = I;
      step(s);
      cmp($sformatf("drain%0d", i),
          rsp(1'b1, 1'b1, 16'h0000, 16'h1000 + 16'(2 * i), 5'(10 + i), 5'(i), 1'b0));
    end
    for (int i = 0; i < 2; i++) begin
      step(I);
      check($sformatf("drain_empty%0d.valid_ls", i), 32'(valid_ls), 32'd0);
    end

    // freeze_back holds the issued op on the port and keeps the next one at head.
    step(dis(1'b1, 5'd1, 1'b1, 16'h0050, 5'd1, 1'b0, 16'h0000, 16'h0000, 5'd1));
    check("frz_dis1.valid_ls", 32'(valid_ls), 32'd0);
    step(dis(1'b1, 5'd2, 1'b1, 16'h0060, 5'd2, 1'b0, 16'h0000, 16'h0000, 5'd2));
    cmp("frz_first", rsp(1'b1, 1'b1, 16'h0000, 16'h0050, 5'd1, 5'd1, 1'b0));
    for (int i = 0; i < 2; i++) begin
      s = I; s.freeze = 1'b1;
      step(s);
      cmp($sformatf("frz_hold%0d", i), rsp(1'b1, 1'b1, 16'h0000, 16'h0050, 5'd1, 5'd1, 1'b0));
    end
    step(I);
    cmp("frz_release", rsp(1'b1, 1'b1, 16'h0000, 16'h0060, 5'd2, 5'd2, 1'b0));
    step(I);
    check("frz_idle.valid_ls", 32'(valid_ls), 32'd0);

    clear_seq(1'b0, "flush");
    clear_seq(1'b1, "rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
